alu_share_arbiter: RTL and testbench

//  Shares the single EXE-stage ALU between NUM_REQ requesters (e.g. main EXE op, address-gen unit).

---
 rtl/alu_share_arbiter_pkg.sv | 33 +++
 rtl/alu_share_arbiter_if.sv | 31 +++
 rtl/alu_share_arbiter_alu.sv | 56 +++++
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the EXE-stage ALU arbiter: command encodings,
// NZCV bit positions and the command legality check.
package alu_share_arbiter_pkg;

   localparam int ALU_W  = 32;
   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

   typedef enum logic [3:0] {
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001
   } exe_cmd_e;

   function automatic logic cmd_legal(input logic [3:0] cmd);
      logic legal;
      case (cmd)
         CMD_MOV, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC,
         CMD_AND, CMD_ORR, CMD_EOR, CMD_MVN: legal = 1'b1;
         default:                            legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters/consumer (master) and the
// shared-ALU arbiter (slave).
interface alu_share_arbiter_if #(
   parameter int NUM_REQ = 2
);
   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_val1;
   logic [NUM_REQ*32-1:0] req_val2;
   logic [NUM_REQ*4-1:0]  req_cmd;
   logic [NUM_REQ-1:0]    req_s;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_res;
   logic [3:0]            rsp_status;
   logic [TAG_W-1:0]      rsp_tag;
   logic                  rsp_err;

   modport master (
      output req_valid, req_val1, req_val2, req_cmd, req_s, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, rsp_status, rsp_tag, rsp_err
   );

   modport slave (
      input  req_valid, req_val1, req_val2, req_cmd, req_s, rsp_ready,
      output req_ready, rsp_valid, rsp_res, rsp_status, rsp_tag, rsp_err
   );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit EXE ALU. Carry is the raw bit 32 of the 33-bit
// operation, so SUB/SBC report a borrow and SBC subtracts the inverted Cin.
module alu_share_arbiter_alu
   import alu_share_arbiter_pkg::*;
(
   input  logic [ALU_W-1:0] i_val1,
   input  logic [ALU_W-1:0] i_val2,
   input  logic [3:0]       i_cmd,
   input  logic             i_cin,
   output logic [ALU_W-1:0] o_res,
   output logic [3:0]       o_nzcv
);

   logic [ALU_W:0] w_wide;
   logic           w_v;

   // Operation select; logical ops leave bit 32 clear and never overflow.
   always_comb begin
      w_wide = '0;
      w_v    = 1'b0;
      case (i_cmd)
         CMD_MOV: w_wide = {1'b0, i_val2};
         CMD_MVN: w_wide = {1'b0, ~i_val2};
         CMD_AND: w_wide = {1'b0, i_val1 & i_val2};
         CMD_ORR: w_wide = {1'b0, i_val1 | i_val2};
         CMD_EOR: w_wide = {1'b0, i_val1 ^ i_val2};
         CMD_ADD, CMD_ADC: begin
            w_wide = {1'b0, i_val1} + {1'b0, i_val2}
                   + {{ALU_W{1'b0}}, (i_cmd == CMD_ADC) & i_cin};
            w_v    = (i_val1[ALU_W-1] == i_val2[ALU_W-1]) &&
                     (w_wide[ALU_W-1] != i_val1[ALU_W-1]);
         end
         CMD_SUB, CMD_SBC: begin
            w_wide = {1'b0, i_val1} - {1'b0, i_val2}
                   - {{ALU_W{1'b0}}, (i_cmd == CMD_SBC) & ~i_cin};
            w_v    = (i_val1[ALU_W-1] != i_val2[ALU_W-1]) &&
                     (w_wide[ALU_W-1] != i_val1[ALU_W-1]);
         end
         default: begin
            w_wide = '0;
            w_v    = 1'b0;
         end
      endcase
   end

   // Flag assembly from the wide result.
   always_comb begin
      o_res          = w_wide[ALU_W-1:0];
      o_nzcv         = 4'b0000;
      o_nzcv[NZCV_N] = w_wide[ALU_W-1];
      o_nzcv[NZCV_Z] = (w_wide[ALU_W-1:0] == {ALU_W{1'b0}});
      o_nzcv[NZCV_C] = w_wide[ALU_W];
      o_nzcv[NZCV_V] = w_v;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of the EXE ALU between NUM_REQ requesters with a single
// registered result slot and ownership of the architectural NZCV register.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   alu_share_arbiter_if.slave bus,
   output logic [3:0]         flags_q
);

   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IDX_W = TAG_W + 1;

   logic [TAG_W-1:0]  r_ptr;
   logic [TAG_W-1:0]  w_grant;
   logic [TAG_W-1:0]  w_ptr_nxt;
   logic [IDX_W-1:0]  w_idx;
   logic              w_found;
   logic              w_can_accept;
   logic              w_accept;
   logic              w_legal;
   logic              w_sel_s;
   logic [NUM_REQ-1:0] w_req_ready;
   logic [DATA_W-1:0] w_sel_val1;
   logic [DATA_W-1:0] w_sel_val2;
   logic [3:0]        w_sel_cmd;
   logic [DATA_W-1:0] w_alu_res;
   logic [3:0]        w_alu_nzcv;

   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_res;
   logic [3:0]        r_rsp_status;
   logic [TAG_W-1:0]  r_rsp_tag;
   logic              r_rsp_err;
   logic [3:0]        r_flags;

   // Round-robin pick: first valid requester at or after r_ptr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = {1'b0, r_ptr} + IDX_W'(k);
         if (w_idx >= IDX_W'(NUM_REQ)) begin
            w_idx = w_idx - IDX_W'(NUM_REQ);
         end else begin
            w_idx = w_idx;
         end
         if (!w_found && bus.req_valid[w_idx[TAG_W-1:0]]) begin
            w_found = 1'b1;
            w_grant = w_idx[TAG_W-1:0];
         end else begin
            w_found = w_found;
         end
      end
   end

   // Handshake: ready is gated by reset so nothing is granted while held.
   always_comb begin
      w_can_accept = !r_rsp_valid || bus.rsp_ready;
      w_accept     = w_found && w_can_accept && rst;
      w_req_ready  = '0;
      if (w_accept) begin
         w_req_ready[w_grant] = 1'b1;
      end else begin
         w_req_ready = '0;
      end
      if (w_grant == TAG_W'(NUM_REQ - 1)) begin
         w_ptr_nxt = '0;
      end else begin
         w_ptr_nxt = w_grant + TAG_W'(1);
      end
   end

   assign w_sel_val1 = bus.req_val1[DATA_W*w_grant +: DATA_W];
   assign w_sel_val2 = bus.req_val2[DATA_W*w_grant +: DATA_W];
   assign w_sel_cmd  = bus.req_cmd[4*w_grant +: 4];
   assign w_sel_s    = bus.req_s[w_grant];
   assign w_legal    = cmd_legal(w_sel_cmd);

   alu_share_arbiter_alu u_alu (
      .i_val1 (w_sel_val1),
      .i_val2 (w_sel_val2),
      .i_cmd  (w_sel_cmd),
      .i_cin  (r_flags[NZCV_C]),
      .o_res  (w_alu_res),
      .o_nzcv (w_alu_nzcv)
   );

   // Result slot: load on accept, drain on consume, otherwise hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_res    <= '0;
         r_rsp_status <= 4'b0000;
         r_rsp_tag    <= '0;
         r_rsp_err    <= 1'b0;
      end else if (w_accept) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_res    <= w_legal ? w_alu_res : {DATA_W{1'b0}};
         r_rsp_status <= w_legal ? w_alu_nzcv : 4'b0000;
         r_rsp_tag    <= w_grant;
         r_rsp_err    <= !w_legal;
      end else if (bus.rsp_ready) begin
         r_rsp_valid  <= 1'b0;
      end else begin
         r_rsp_valid  <= r_rsp_valid;
      end
   end

   // Arbitration pointer and NZCV; illegal commands never touch the flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr   <= '0;
         r_flags <= 4'b0000;
      end else if (w_accept) begin
         r_ptr <= w_ptr_nxt;
         if (w_sel_s && w_legal) begin
            r_flags <= w_alu_nzcv;
         end else begin
            r_flags <= r_flags;
         end
      end else begin
         r_ptr   <= r_ptr;
         r_flags <= r_flags;
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_res    = r_rsp_res;
   assign bus.rsp_status = r_rsp_status;
   assign bus.rsp_tag    = r_rsp_tag;
   assign bus.rsp_err    = r_rsp_err;
   assign flags_q        = r_flags;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: arithmetic reference model with
// per-cycle comparison plus hand-computed expectations.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   typedef struct packed {
      logic        valid;
      logic [31:0] res;
      logic [3:0]  st;
      logic        tag;
      logic        err;
      logic [3:0]  flags;
      logic        ptr;
   } mstate_t;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] flags_q;
   int         n_tests;
   int         n_fail;
   mstate_t    m;
   vec_t       tbl [0:9];

   alu_share_arbiter_if #(.NUM_REQ(2)) bus ();

   alu_share_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
      .clk     (clk),
      .rst     (rst_n),
      .bus     (bus),
      .flags_q (flags_q)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {err, res[31:0], N, Z, C, V}
   function automatic logic [36:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] cmd, logic cin);
      longint ua, ub, sa, sb, w, sw, extra;
      logic [31:0] r;
      logic c, v;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      r = 32'd0; c = 1'b0; v = 1'b0; extra = 64'sd0;
      case (cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         4'd2, 4'd3: begin
            extra = (cmd == 4'd3 && cin) ? 64'sd1 : 64'sd0;
            w  = ua + ub + extra;
            sw = sa + sb + extra;
            r  = w[31:0];
            c  = (w > 64'sd4294967295);
            v  = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
         end
         4'd4, 4'd5: begin
            extra = (cmd == 4'd5 && !cin) ? 64'sd1 : 64'sd0;
            w  = ua - ub - extra;
            sw = sa - sb - extra;
            r  = w[31:0];
            c  = (ua < ub + extra);
            v  = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
         end
         default: return {1'b1, 36'd0};
      endcase
      return {1'b0, r, r[31], (r == 32'd0), c, v};
   endfunction

   function automatic int pick(logic ptr, logic [1:0] v);
      int g;
      g = -1;
      for (int k = 1; k >= 0; k--) begin
         if (v[(int'(ptr) + k) % 2]) g = (int'(ptr) + k) % 2;
      end
      return g;
   endfunction

   function automatic mstate_t step(mstate_t s);
      mstate_t     n;
      int          g;
      logic [36:0] r;
      n = s;
      g = pick(s.ptr, bus.req_valid);
      if (g >= 0 && (!s.valid || bus.rsp_ready)) begin
         r = alu_ref(bus.req_val1[32*g +: 32], bus.req_val2[32*g +: 32],
                     bus.req_cmd[4*g +: 4], s.flags[1]);
         n.valid = 1'b1;
         n.err   = r[36];
         n.res   = r[35:4];
         n.st    = r[3:0];
         n.tag   = (g == 1);
         if (bus.req_s[g] && !r[36]) n.flags = r[3:0];
         n.ptr   = (g == 0);
      end else if (bus.rsp_ready) begin
         n.valid = 1'b0;
      end
      return n;
   endfunction

   function automatic logic [1:0] exp_ready();
      int         g;
      logic [1:0] one;
      one = 2'b01;
      g = pick(m.ptr, bus.req_valid);
      if (rst_n && g >= 0 && (!m.valid || bus.rsp_ready)) return one << g;
      return 2'b00;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= step(m);
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("req_ready", bus.req_ready, exp_ready());
      chk("rsp_valid", bus.rsp_valid, m.valid);
      chk("flags_q", flags_q, m.flags);
      if (m.valid) begin
         chk("rsp_res", bus.rsp_res, m.res);
         chk("rsp_status", bus.rsp_status, m.st);
         chk("rsp_tag", bus.rsp_tag, m.tag);
         chk("rsp_err", bus.rsp_err, m.err);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic set_req(int i, logic v, logic [3:0] cmd, logic [31:0] a, logic [31:0] b, logic s);
      bus.req_valid[i]        = v;
      bus.req_cmd[4*i +: 4]   = cmd;
      bus.req_val1[32*i +: 32] = a;
      bus.req_val2[32*i +: 32] = b;
      bus.req_s[i]            = s;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.req_valid = 2'b00; bus.req_val1 = '0; bus.req_val2 = '0;
      bus.req_cmd = '0; bus.req_s = 2'b00; bus.rsp_ready = 1'b1;
      tbl[0] = '{CMD_MOV, 32'h0, 32'hDEAD_BEEF, 1'b1};
      tbl[1] = '{CMD_MVN, 32'h0, 32'h0, 1'b1};
      tbl[2] = '{CMD_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1};
      tbl[3] = '{CMD_EOR, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0};
      tbl[4] = '{CMD_SUB, 32'd3, 32'd5, 1'b1};
      tbl[5] = '{CMD_SBC, 32'd10, 32'd3, 1'b1};
      tbl[6] = '{CMD_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1};
      tbl[7] = '{CMD_ADC, 32'd1, 32'd1, 1'b1};
      tbl[8] = '{4'b1010, 32'd1, 32'd2, 1'b1};
      tbl[9] = '{CMD_ORR, 32'h0, 32'h0, 1'b1};

      // T1: reset held with both requesters active
      set_req(0, 1'b1, CMD_ADD, 32'd10, 32'd20, 1'b0);
      set_req(1, 1'b1, CMD_SUB, 32'd100, 32'd1, 1'b0);
      tick();
      tick();
      chk("t1_rsp_valid", bus.rsp_valid, 1'b0);
      chk("t1_rsp_res", bus.rsp_res, 32'd0);
      chk("t1_rsp_status", bus.rsp_status, 4'd0);
      chk("t1_rsp_tag", bus.rsp_tag, 1'b0);
      chk("t1_rsp_err", bus.rsp_err, 1'b0);
      chk("t1_flags_q", flags_q, 4'd0);
      chk("t1_req_ready", bus.req_ready, 2'b00);
      rst_n = 1'b1;
      #1;
      chk("t1_first_grant", bus.req_ready, 2'b01);

      // T2: contention, alternating tags, one result per cycle
      for (int j = 0; j < 6; j++) begin
         tick();
         chk("t2_valid", bus.rsp_valid, 1'b1);
         chk("t2_tag", bus.rsp_tag, (j % 2 == 1));
         chk("t2_res", bus.rsp_res, (j % 2 == 1) ? 32'd99 : 32'd30);
      end
      set_req(0, 1'b0, CMD_ADD, 32'd0, 32'd0, 1'b0);
      set_req(1, 1'b0, CMD_ADD, 32'd0, 32'd0, 1'b0);
      tick();
      chk("t2_drained", bus.rsp_valid, 1'b0);

      // T3: backpressure holds the slot, release accepts in the same cycle
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b1, CMD_ADD, 32'd5, 32'd7, 1'b0);
      tick();
      set_req(0, 1'b1, CMD_ORR, 32'h0000_00F0, 32'h0000_000F, 1'b0);
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("t3_held_res", bus.rsp_res, 32'd12);
         chk("t3_held_valid", bus.rsp_valid, 1'b1);
         chk("t3_blocked", bus.req_ready, 2'b00);
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("t3_same_cycle", bus.req_ready, 2'b01);
      tick();
      chk("t3_next_res", bus.rsp_res, 32'h0000_00FF);
      set_req(0, 1'b0, CMD_ADD, 32'd0, 32'd0, 1'b0);
      tick();

      // T4: carry generation then consumption by ADC
      set_req(0, 1'b1, CMD_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
      tick();
      chk("t4_add_res", bus.rsp_res, 32'd0);
      chk("t4_add_nzcv", bus.rsp_status, 4'b0110);
      chk("t4_flags", flags_q, 4'b0110);
      set_req(0, 1'b0, CMD_ADD, 32'd0, 32'd0, 1'b0);
      set_req(1, 1'b1, CMD_ADC, 32'd3, 32'd4, 1'b0);
      tick();
      chk("t4_adc_res", bus.rsp_res, 32'd8);
      chk("t4_adc_tag", bus.rsp_tag, 1'b1);
      chk("t4_flags_kept", flags_q, 4'b0110);
      set_req(1, 1'b0, CMD_ADC, 32'd0, 32'd0, 1'b0);

      // T5: signed overflow on SUB
      set_req(0, 1'b1, CMD_SUB, 32'h8000_0000, 32'd1, 1'b1);
      tick();
      chk("t5_res", bus.rsp_res, 32'h7FFF_FFFF);
      chk("t5_v", bus.rsp_status[0], 1'b1);
      chk("t5_n", bus.rsp_status[3], 1'b0);

      // T6: illegal command leaves flags alone
      set_req(0, 1'b1, 4'b1111, 32'd5, 32'd6, 1'b1);
      tick();
      chk("t6_err", bus.rsp_err, 1'b1);
      chk("t6_res", bus.rsp_res, 32'd0);
      chk("t6_status", bus.rsp_status, 4'd0);
      chk("t6_flags", flags_q, 4'b0001);
      set_req(0, 1'b0, CMD_ADD, 32'd0, 32'd0, 1'b0);
      tick();

      // Mixed operations on alternating requesters, checked by the model
      for (int k = 0; k < 10; k++) begin
         set_req(1 - (k % 2), 1'b0, CMD_ADD, 32'd0, 32'd0, 1'b0);
         set_req(k % 2, 1'b1, tbl[k].cmd, tbl[k].a, tbl[k].b, tbl[k].s);
         tick();
      end
      set_req(0, 1'b0, CMD_ADD, 32'd0, 32'd0, 1'b0);
      set_req(1, 1'b0, CMD_ADD, 32'd0, 32'd0, 1'b0);
      tick();

      // Reset while a result is waiting in the slot
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b1, CMD_ADD, 32'd1, 32'd1, 1'b1);
      tick();
      chk("t6_slot_full", bus.rsp_valid, 1'b1);
      set_req(0, 1'b0, CMD_ADD, 32'd0, 32'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_clear", bus.rsp_valid, 1'b0);
      chk("t6_async_flags", flags_q, 4'd0);
      tick();
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      tick();
      tick();
      chk("t6_no_stale", bus.rsp_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
